lap_recorder: RTL and testbench

//  Stores lap times (4 BCD digits: mm:ss) into a circular RAM on a save strobe and

---
 rtl/watch_pkg.sv | 31 +++
 rtl/lap_ram.sv | 29 ++
 rtl/lap_recorder.sv | 229 ++++++++++++++++++++++
 tb/tb_lap_recorder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants, state encoding and lap word layout for the stopwatch lap store.
//   SIZE        width of one BCD digit
//   LAP_W       width of one stored lap (four digits)
//   DEPTH       number of lap entries (power of two)
//   ADDR_W      log2(DEPTH)
//   CNT_W       width of the lap counter (0..DEPTH)
//   SHOW_PULSES 1 s pulses a recalled lap stays on the display
package watch_pkg;

    localparam int unsigned SIZE        = 4;
    localparam int unsigned LAP_W       = 4 * SIZE;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned CNT_W       = ADDR_W + 1;
    localparam int unsigned SHOW_PULSES = 5;
    localparam int unsigned SHOW_W      = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_SHOW  = 2'd3;

    // One lap entry, minute tens in the top nibble down to second units.
    typedef struct packed {
        logic [SIZE-1:0] mt;
        logic [SIZE-1:0] mu;
        logic [SIZE-1:0] st;
        logic [SIZE-1:0] su;
    } lap_t;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: DEPTH x LAP_W, synchronous write, synchronous read (1-cycle latency).
// No reset on the array; contents are undefined until written.
//   clk    system clock
//   we     write enable
//   waddr  write address
//   wdata  lap word to write
//   raddr  read address, sampled every cycle
//   rdata  registered read data (old data on same-address read/write)
module lap_ram
    import watch_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  lap_t              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output lap_t              rdata
);

    lap_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap recorder: saves the current mm:ss into a circular lap store on a save strobe and
// replays stored laps oldest-first on recall, each shown for SHOW_PULSES 1 s pulses.
// Configuration macro: LAP_OVERWRITE_EN -- when defined a save into a full store
// overwrites the oldest lap; when undefined it is dropped and overflow is set.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   pulse                      1 s tick, one clk wide
//   save / recall / clear      one-clk command strobes (priority clear > save > recall)
//   su_in, st_in, mu_in, mt_in current time digits
//   su_out..mt_out             recalled digits
//   recall_valid               recalled digits on display
//   we, addr                   RAM write enable / address mirror for the display path
//   count, empty, full         number of stored laps and its flags
//   overflow                   sticky: a save was dropped while full
module lap_recorder
    import watch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic              save,
    input  logic              recall,
    input  logic              clear,
    input  logic [SIZE-1:0]   su_in,
    input  logic [SIZE-1:0]   st_in,
    input  logic [SIZE-1:0]   mu_in,
    input  logic [SIZE-1:0]   mt_in,
    output logic [SIZE-1:0]   su_out,
    output logic [SIZE-1:0]   st_out,
    output logic [SIZE-1:0]   mu_out,
    output logic [SIZE-1:0]   mt_out,
    output logic              recall_valid,
    output logic              we,
    output logic [7:0]        addr,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

`ifdef LAP_OVERWRITE_EN
    localparam bit OVERWRITE_EN = 1'b1;
`else
    localparam bit OVERWRITE_EN = 1'b0;
`endif

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W-1:0] oldest_q,   oldest_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [SHOW_W-1:0] show_cnt_q, show_cnt_d;
    lap_t              cap_q,      cap_d;
    lap_t              dout_q,     dout_d;
    logic              rv_q,       rv_d;
    logic              we_q,       we_d;
    logic [7:0]        addr_q,     addr_d;
    logic              empty_q,    empty_d;
    logic              full_q,     full_d;
    logic              ovf_q,      ovf_d;

    lap_t              lap_in;
    lap_t              ram_rdata;
    logic              can_write;
    logic [ADDR_W-1:0] rd_next;

    assign lap_in    = {mt_in, mu_in, st_in, su_in};
    assign can_write = OVERWRITE_EN || !full_q;
    // Past the newest entry the read pointer wraps back to the oldest one.
    assign rd_next   = (ADDR_W'(rd_ptr_q + 1'b1) == wr_ptr_q) ? oldest_q
                                                              : ADDR_W'(rd_ptr_q + 1'b1);

    // Lap storage; reads always track rd_ptr so data is ready one cycle after READ starts.
    lap_ram u_ram (
        .clk   (clk),
        .we    (state_q == ST_WRITE),
        .waddr (wr_ptr_q),
        .wdata (cap_q),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            oldest_q   <= '0;
            count_q    <= '0;
            show_cnt_q <= '0;
            cap_q      <= '0;
            dout_q     <= '0;
            rv_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            oldest_q   <= oldest_d;
            count_q    <= count_d;
            show_cnt_q <= show_cnt_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            rv_q       <= rv_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        oldest_d   = oldest_q;
        count_d    = count_q;
        show_cnt_d = show_cnt_q;
        cap_d      = cap_q;
        dout_d     = dout_q;
        rv_d       = rv_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (save) begin
                    if (can_write) begin
                        state_d = ST_WRITE;
                        cap_d   = lap_in;
                        we_d    = 1'b1;
                        addr_d  = 8'(wr_ptr_q);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (recall && !empty_q) begin
                    state_d = ST_READ;
                    addr_d  = 8'(rd_ptr_q);
                end
            end
            ST_WRITE: begin
                wr_ptr_d = ADDR_W'(wr_ptr_q + 1'b1);
                // A full store only reaches WRITE when overwriting: the oldest lap is lost.
                if (full_q) begin
                    oldest_d = ADDR_W'(oldest_q + 1'b1);
                end else begin
                    count_d = CNT_W'(count_q + 1'b1);
                end
                rd_ptr_d = oldest_d;
                state_d  = ST_IDLE;
            end
            ST_READ: begin
                dout_d     = ram_rdata;
                rd_ptr_d   = rd_next;
                show_cnt_d = '0;
                rv_d       = 1'b1;
                state_d    = ST_SHOW;
            end
            ST_SHOW: begin
                if (save) begin
                    if (can_write) begin
                        state_d = ST_WRITE;
                        cap_d   = lap_in;
                        we_d    = 1'b1;
                        addr_d  = 8'(wr_ptr_q);
                        rv_d    = 1'b0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (recall) begin
                    state_d = ST_READ;
                    addr_d  = 8'(rd_ptr_q);
                    rv_d    = 1'b0;
                end else if (pulse) begin
                    if (show_cnt_q == SHOW_W'(SHOW_PULSES - 1)) begin
                        state_d = ST_IDLE;
                        rv_d    = 1'b0;
                    end else begin
                        show_cnt_d = SHOW_W'(show_cnt_q + 1'b1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear overrides everything, including a WRITE commit on the same edge.
        if (clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            oldest_d   = '0;
            count_d    = '0;
            show_cnt_d = '0;
            dout_d     = '0;
            rv_d       = 1'b0;
            we_d       = 1'b0;
            addr_d     = '0;
            ovf_d      = 1'b0;
        end

        if (OVERWRITE_EN) begin
            ovf_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    assign su_out       = dout_q.su;
    assign st_out       = dout_q.st;
    assign mu_out       = dout_q.mu;
    assign mt_out       = dout_q.mt;
    assign recall_valid = rv_q;
    assign we           = we_q;
    assign addr         = addr_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder: a reference model of the lap store predicts each
// recalled lap, pushes it to a scoreboard queue at the recall strobe and compares it
// when the recorder raises recall_valid.
module tb_lap_recorder;
    import watch_pkg::*;

`ifdef LAP_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pulse = 1'b0, save = 1'b0, recall = 1'b0, clear = 1'b0;
    logic [SIZE-1:0] su_in = '0, st_in = '0, mu_in = '0, mt_in = '0;
    logic [SIZE-1:0] su_out, st_out, mu_out, mt_out;
    logic            recall_valid, we, empty, full, overflow;
    logic [7:0]      addr;
    logic [ADDR_W:0] count;

    lap_recorder dut (
        .clk(clk), .rst(rst), .pulse(pulse), .save(save), .recall(recall), .clear(clear),
        .su_in(su_in), .st_in(st_in), .mu_in(mu_in), .mt_in(mt_in),
        .su_out(su_out), .st_out(st_out), .mu_out(mu_out), .mt_out(mt_out),
        .recall_valid(recall_valid), .we(we), .addr(addr), .count(count),
        .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model of the lap store.
    logic [15:0] m_mem [DEPTH];
    int m_wr, m_old, m_cnt, m_ridx;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_wr = 0; m_old = 0; m_cnt = 0; m_ridx = 0;
    endtask

    task automatic do_save(input logic [15:0] lap);
        {mt_in, mu_in, st_in, su_in} = lap;
        save = 1'b1;
        tick();
        save = 1'b0;
        if (m_cnt == DEPTH && !OVW) begin
            chk("drop_we", 32'(we), 32'd0);
        end else begin
            chk("write_we", 32'(we), 32'd1);
            chk("write_addr", 32'(addr), 32'(m_wr));
            m_mem[m_wr] = lap;
            m_wr = (m_wr + 1) % DEPTH;
            if (m_cnt == DEPTH) m_old = (m_old + 1) % DEPTH;
            else                m_cnt++;
            m_ridx = 0;
            tick();
        end
    endtask

    // Recall and verify the two-clock latency, then pop the expected lap.
    task automatic do_recall();
        int a;
        logic [15:0] exp;
        a = (m_old + m_ridx) % DEPTH;
        sb.push_back(m_mem[a]);
        m_ridx = (m_ridx + 1) % m_cnt;
        recall = 1'b1;
        tick();
        recall = 1'b0;
        chk("read_rv", 32'(recall_valid), 32'd0);
        chk("read_addr", 32'(addr), 32'(a));
        tick();
        chk("show_rv", 32'(recall_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk("lap_digits", 32'({mt_out, mu_out, st_out, su_out}), 32'(exp));
        end
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        sb.delete();
    endtask

    initial begin
        model_clear();
        // Reset values
        repeat (2) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rv", 32'(recall_valid), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_digits", 32'({mt_out, mu_out, st_out, su_out}), 32'd0);
        rst = 1'b1;
        tick();

        // Recall on empty store is ignored
        recall = 1'b1; tick(); recall = 1'b0; tick();
        chk("empty_recall_rv", 32'(recall_valid), 32'd0);

        // 12:34 saved, recalled and timed out after SHOW_PULSES pulses
        do_save(16'h1234);
        chk("one_count", 32'(count), 32'd1);
        chk("one_empty", 32'(empty), 32'd0);
        do_recall();
        for (int i = 0; i < SHOW_PULSES - 1; i++) do_pulse();
        chk("show_hold", 32'(recall_valid), 32'd1);
        do_pulse();
        chk("show_timeout", 32'(recall_valid), 32'd0);

        // Three laps recalled four times: wraps to the oldest
        do_clear();
        chk("clr_count", 32'(count), 32'd0);
        for (int k = 1; k <= 3; k++) do_save(16'(k));
        for (int k = 0; k < 4; k++) do_recall();

        // Nine saves into an eight-deep store
        do_clear();
        for (int k = 1; k <= 9; k++) do_save(16'(k));
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ovf", 32'(overflow), OVW ? 32'd0 : 32'd1);
        do_recall();
        do_recall();

        // Save and recall on the same edge: write only
        do_clear();
        chk("clr_ovf", 32'(overflow), 32'd0);
        {mt_in, mu_in, st_in, su_in} = 16'h0742;
        save = 1'b1; recall = 1'b1;
        tick();
        save = 1'b0; recall = 1'b0;
        chk("sr_we", 32'(we), 32'd1);
        m_mem[0] = 16'h0742; m_wr = 1; m_cnt = 1; m_ridx = 0;
        tick();
        chk("sr_count", 32'(count), 32'd1);
        repeat (3) tick();
        chk("sr_rv", 32'(recall_valid), 32'd0);

        // Clear on the WRITE commit edge wins
        do_clear();
        {mt_in, mu_in, st_in, su_in} = 16'h0101;
        save = 1'b1; tick(); save = 1'b0;
        chk("cw_we", 32'(we), 32'd1);
        do_clear();
        chk("cw_count", 32'(count), 32'd0);
        chk("cw_empty", 32'(empty), 32'd1);
        recall = 1'b1; tick(); recall = 1'b0;
        repeat (3) tick();
        chk("cw_recall_rv", 32'(recall_valid), 32'd0);

        // Asynchronous reset in the middle of SHOW
        do_save(16'h0559);
        do_recall();
        #2;
        rst = 1'b0;
        #1;
        chk("ars_rv", 32'(recall_valid), 32'd0);
        chk("ars_count", 32'(count), 32'd0);
        chk("ars_empty", 32'(empty), 32'd1);
        chk("ars_digits", 32'({mt_out, mu_out, st_out, su_out}), 32'd0);
        chk("ars_addr", 32'(addr), 32'd0);
        model_clear();
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
